// File: rtl/shift_add_multiplier_8bit_pkg.sv
// rtl/shift_add_multiplier_8bit_pkg.sv - shared constants and state encoding for the shift-add multiplier
package shift_add_multiplier_8bit_pkg;

  localparam int WIDTH  = 8;
  localparam int CNT_W  = 3;
  localparam int PROD_W = 2 * WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

endpackage

// File: rtl/shift_add_multiplier_8bit_if.sv
// rtl/shift_add_multiplier_8bit_if.sv - start/done handshake and operand/product bus
interface shift_add_multiplier_8bit_if;
  import shift_add_multiplier_8bit_pkg::*;

  logic              start;
  logic [WIDTH-1:0]  multiplicand;
  logic [WIDTH-1:0]  multiplier;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );

endinterface

// File: rtl/ripplecarry_adder_8bit.sv
// rtl/ripplecarry_adder_8bit.sv - 8-bit ripple-carry adder built from a chain of full adders
module ripplecarry_adder_8bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic [8:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar g = 0; g < 8; g++) begin : g_fa
    assign o_sum[g]     = i_a[g] ^ i_b[g] ^ w_carry[g];
    assign w_carry[g+1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_carry[8];

endmodule

// File: rtl/shift_add_multiplier_8bit.sv
// rtl/shift_add_multiplier_8bit.sv - sequential unsigned 8x8 shift-and-add multiplier, one accumulate per clock
module shift_add_multiplier_8bit
  import shift_add_multiplier_8bit_pkg::*;
#(
  parameter int P_WIDTH = WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  shift_add_multiplier_8bit_if.slave   bus
);

  if (P_WIDTH != 8) begin : g_width_check
    $error("shift_add_multiplier_8bit supports only an 8-bit operand width");
  end

  state_t            r_state;
  state_t            w_next_state;
  logic [WIDTH-1:0]  r_m;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_q;
  logic              r_c;
  logic [CNT_W-1:0]  r_cnt;
  logic [PROD_W-1:0] r_product;

  logic [WIDTH-1:0]  w_addend;
  logic [WIDTH-1:0]  w_sum;
  logic              w_cout;
  logic              w_load;
  logic              w_iter;
  logic              w_last;

  assign w_addend = r_q[0] ? r_m : '0;

  // C is cleared on load and after every iteration, so the adder always sees Cin=0.
  ripplecarry_adder_8bit u_adder (
    .i_a    (r_acc),
    .i_b    (w_addend),
    .i_cin  (r_c),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_load = bus.start && (r_state == IDLE || r_state == DONE);
  assign w_iter = (r_state == BUSY);
  assign w_last = w_iter && (r_cnt == LAST_ITER);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next_state = BUSY;
      end
      BUSY: begin
        bus.busy = 1'b1;
        if (r_cnt == LAST_ITER) w_next_state = DONE;
      end
      DONE: begin
        bus.done     = 1'b1;
        w_next_state = bus.start ? BUSY : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_m       <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_c       <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_load) begin
      r_m   <= bus.multiplicand;
      r_q   <= bus.multiplier;
      r_acc <= '0;
      r_c   <= 1'b0;
      r_cnt <= '0;
    end else if (w_iter) begin
      // {C,ACC,Q} <= {0, cout, sum, Q} >> 1
      r_c   <= 1'b0;
      r_acc <= {w_cout, w_sum[WIDTH-1:1]};
      r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_product <= {w_cout, w_sum, r_q[WIDTH-1:1]};
      end
    end
  end

  assign bus.product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier_8bit.sv
// tb/tb_shift_add_multiplier_8bit.sv - directed, table-driven bench for the shift-add multiplier
module tb_shift_add_multiplier_8bit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  shift_add_multiplier_8bit_if u_if ();

  shift_add_multiplier_8bit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Called at a negedge; counts busy cycles until done is seen (done cycle is the exit point).
  task automatic wait_done(output int busy_cnt, output int overlap, output bit seen);
    int cycles = 0;
    busy_cnt = 0;
    overlap  = 0;
    seen     = 1'b0;
    while (cycles < 30) begin
      if (u_if.busy && u_if.done) overlap++;
      if (u_if.done) begin
        seen = 1'b1;
        break;
      end
      if (u_if.busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                         input string name);
    int  bc, ov;
    bit  seen;
    @(negedge clk);
    u_if.start        = 1'b1;
    u_if.multiplicand = a;
    u_if.multiplier   = b;
    @(negedge clk);
    u_if.start = 1'b0;
    wait_done(bc, ov, seen);
    check({name, " done_seen"}, 32'(seen), 32'd1);
    check({name, " busy_cycles"}, 32'(bc), 32'd8);
    check({name, " busy_done_overlap"}, 32'(ov), 32'd0);
    check({name, " product"}, 32'(u_if.product), 32'(exp));
    @(negedge clk);
    check({name, " done_single_pulse"}, 32'(u_if.done), 32'd0);
    check({name, " product_held"}, 32'(u_if.product), 32'(exp));
  endtask

  initial begin
    int  bc, ov, dcnt;
    bit  seen;

    vecs[0] = '{8'h0D, 8'h0B, 16'h008F};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hFF, 16'h0000};
    vecs[3] = '{8'h80, 8'h02, 16'h0100};
    vecs[4] = '{8'h01, 8'h01, 16'h0001};
    vecs[5] = '{8'hFF, 8'h01, 16'h00FF};
    vecs[6] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[7] = '{8'h0F, 8'h0F, 16'h00E1};
    vecs[8] = '{8'hAA, 8'h55, 16'h3872};
    vecs[9] = '{8'h12, 8'h34, 16'h03A8};

    u_if.start        = 1'b0;
    u_if.multiplicand = 8'h00;
    u_if.multiplier   = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(u_if.busy), 32'd0);
    check("reset done", 32'(u_if.done), 32'd0);
    check("reset product", 32'(u_if.product), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_mul(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // start pulsed during BUSY must be ignored
    @(negedge clk);
    u_if.start = 1'b1; u_if.multiplicand = 8'h03; u_if.multiplier = 8'h05;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (2) @(negedge clk);
    u_if.start = 1'b1; u_if.multiplicand = 8'h10; u_if.multiplier = 8'h10;
    @(negedge clk);
    u_if.start = 1'b0;
    wait_done(bc, ov, seen);
    check("ignore done_seen", 32'(seen), 32'd1);
    check("ignore busy_cycles", 32'(bc + 3), 32'd8);
    check("ignore product", 32'(u_if.product), 32'h000F);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (u_if.done || u_if.busy) dcnt++;
    end
    check("ignore no_second_run", 32'(dcnt), 32'd0);

    // back-to-back: start held in the DONE cycle
    @(negedge clk);
    u_if.start = 1'b1; u_if.multiplicand = 8'h03; u_if.multiplier = 8'h05;
    @(negedge clk);
    u_if.start = 1'b0;
    wait_done(bc, ov, seen);
    check("b2b first done_seen", 32'(seen), 32'd1);
    u_if.start = 1'b1; u_if.multiplicand = 8'h02; u_if.multiplier = 8'h07;
    check("b2b prev product", 32'(u_if.product), 32'h000F);
    @(negedge clk);
    u_if.start = 1'b0;
    check("b2b no_idle_gap", 32'(u_if.busy), 32'd1);
    check("b2b product_kept", 32'(u_if.product), 32'h000F);
    wait_done(bc, ov, seen);
    check("b2b second done_seen", 32'(seen), 32'd1);
    check("b2b busy_cycles", 32'(bc), 32'd8);
    check("b2b product", 32'(u_if.product), 32'h000E);
    @(negedge clk);

    // reset in the 4th BUSY cycle aborts silently
    @(negedge clk);
    u_if.start = 1'b1; u_if.multiplicand = 8'h0D; u_if.multiplier = 8'h0B;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort busy_before", 32'(u_if.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(u_if.busy), 32'd0);
    check("abort done", 32'(u_if.done), 32'd0);
    check("abort product", 32'(u_if.product), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (u_if.done || u_if.busy) dcnt++;
    end
    check("abort no_done", 32'(dcnt), 32'd0);
    run_mul(8'h0D, 8'h0B, 16'h008F, "post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
